// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan capture: active-low segment
// patterns (gfedcba) for 0-9 and the active-low single-anode codes.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;
   localparam logic [3:0] AN_NONE = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment to BCD decoder. Patterns outside
// 0-9 decode to 4'hF with valid_o low.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       valid_o
);

   // Pattern lookup; anything unrecognised falls through to the defaults.
   always_comb begin
      bcd_o   = 4'hF;
      valid_o = 1'b1;
      case (seg_i)
         SEG_0:   bcd_o = 4'd0;
         SEG_1:   bcd_o = 4'd1;
         SEG_2:   bcd_o = 4'd2;
         SEG_3:   bcd_o = 4'd3;
         SEG_4:   bcd_o = 4'd4;
         SEG_5:   bcd_o = 4'd5;
         SEG_6:   bcd_o = 4'd6;
         SEG_7:   bcd_o = 4'd7;
         SEG_8:   bcd_o = 4'd8;
         SEG_9:   bcd_o = 4'd9;
         default: valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitor for a multiplexed 4-digit seven-segment display. Waits for each
// digit dwell to settle, decodes it into a per-digit slot and publishes a
// whole frame once all four digits have been seen.
// Optional macro SEG7_CAP_SYNC_EN: adds a 2-flop synchronizer on an/seg.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int STALE_CYCLES  = 2000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  an_i,
   input  logic [6:0]  seg_i,
   output logic [15:0] digits_o,
   output logic [3:0]  frame_err_o,
   output logic        frame_valid_o,
   output logic        stale_o,
   output logic        anode_conflict_o
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(STALE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] STALE_MAX = TW'(STALE_CYCLES);

   logic [10:0] pins;

`ifdef SEG7_CAP_SYNC_EN
   logic [10:0] sync1_q, sync2_q;

   // Two-stage synchronizer for pins driven from another clock domain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {an_i, seg_i};
         sync2_q <= sync1_q;
      end
   end
   assign pins = sync2_q;
`else
   assign pins = {an_i, seg_i};
`endif

   logic [10:0]      smp_q, prev_q;
   logic [SW-1:0]    stab_q, stab_d;
   logic             captured_q, captured_d;
   logic [3:0][3:0]  slot_q, slot_d;
   logic [3:0]       err_q, err_d;
   logic [3:0]       seen_q, seen_d;
   logic [3:0][3:0]  digits_q, digits_d;
   logic [3:0]       ferr_q, ferr_d;
   logic             fv_q, fv_d;
   logic [TW-1:0]    stale_cnt_q, stale_cnt_d;
   logic             stale_q, stale_d;
   logic             conflict_q, conflict_d;

   logic [3:0] bcd;
   logic       bcd_ok;
   logic       same, cap, dig_hit, done;
   logic [1:0] idx;

   seg7_decode u_dec (
      .seg_i   (smp_q[6:0]),
      .bcd_o   (bcd),
      .valid_o (bcd_ok)
   );

   // Next-state: stability tracking, capture into slots, frame hand-off,
   // stale timer and sticky anode conflict.
   always_comb begin
      same    = (smp_q == prev_q);
      cap     = same && (stab_q == STAB_MAX) && !captured_q;
      done    = (seen_q == 4'b1111);
      dig_hit = 1'b1;
      idx     = 2'd0;
      case (smp_q[10:7])
         AN_DIG0: idx = 2'd0;
         AN_DIG1: idx = 2'd1;
         AN_DIG2: idx = 2'd2;
         AN_DIG3: idx = 2'd3;
         default: dig_hit = 1'b0;
      endcase

      stab_d     = !same ? '0 : (stab_q == STAB_MAX ? stab_q : stab_q + SW'(1));
      captured_d = !same ? 1'b0 : (captured_q | cap);

      slot_d = slot_q;
      err_d  = err_q;
      // A completed mask is cleared on hand-off, but a capture landing on
      // the same edge must still be recorded for the next frame.
      seen_d = done ? 4'b0000 : seen_q;
      if (cap && dig_hit) begin
         slot_d[idx] = bcd;
         err_d[idx]  = !bcd_ok;
         seen_d[idx] = 1'b1;
      end

      conflict_d = conflict_q | (cap && !dig_hit && (smp_q[10:7] != AN_NONE));

      digits_d = done ? slot_q : digits_q;
      ferr_d   = done ? err_q  : ferr_q;
      fv_d     = done;

      // Frame completion beats a simultaneous timeout.
      if (done) begin
         stale_cnt_d = '0;
         stale_d     = 1'b0;
      end else begin
         stale_cnt_d = (stale_cnt_q == STALE_MAX) ? stale_cnt_q : stale_cnt_q + TW'(1);
         stale_d     = (stale_cnt_d == STALE_MAX);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         smp_q       <= '0;
         prev_q      <= '0;
         stab_q      <= '0;
         captured_q  <= 1'b0;
         slot_q      <= '0;
         err_q       <= '0;
         seen_q      <= '0;
         digits_q    <= '0;
         ferr_q      <= '0;
         fv_q        <= 1'b0;
         stale_cnt_q <= '0;
         stale_q     <= 1'b0;
         conflict_q  <= 1'b0;
      end else begin
         smp_q       <= pins;
         prev_q      <= smp_q;
         stab_q      <= stab_d;
         captured_q  <= captured_d;
         slot_q      <= slot_d;
         err_q       <= err_d;
         seen_q      <= seen_d;
         digits_q    <= digits_d;
         ferr_q      <= ferr_d;
         fv_q        <= fv_d;
         stale_cnt_q <= stale_cnt_d;
         stale_q     <= stale_d;
         conflict_q  <= conflict_d;
      end
   end

   assign digits_o         = digits_q;
   assign frame_err_o      = ferr_q;
   assign frame_valid_o    = fv_q;
   assign stale_o          = stale_q;
   assign anode_conflict_o = conflict_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: table of full-frame scans plus
// hand-written sequences for short dwell, conflict, reset and stale tie.
module tb_seg7_scan_capture;

   localparam int STABLE = 4;
   localparam int STALE  = 60;
`ifdef SEG7_CAP_SYNC_EN
   localparam int LAT_ADJ = 2;
`else
   localparam int LAT_ADJ = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an  = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic [15:0] digits;
   logic [3:0]  frame_err;
   logic        frame_valid, stale, conflict;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fv_total = 0;
   int fv_cyc = 0;
   logic [15:0] fv_dig = '0;
   logic [3:0]  fv_err = '0;
   logic        fv_stale = 1'b0;

   seg7_scan_capture #(.STABLE_CYCLES(STABLE), .STALE_CYCLES(STALE)) dut (
      .clk_i(clk), .rst_i(rst), .an_i(an), .seg_i(seg),
      .digits_o(digits), .frame_err_o(frame_err), .frame_valid_o(frame_valid),
      .stale_o(stale), .anode_conflict_o(conflict)
   );

   always #5 clk = ~clk;

   // Edge count since the last reset edge.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   // Record every frame_valid pulse as seen at the falling edge.
   always @(negedge clk) begin
      if (frame_valid) begin
         fv_total = fv_total + 1;
         fv_cyc   = cyc;
         fv_dig   = digits;
         fv_err   = frame_err;
         fv_stale = stale;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic show(input int k, input logic [6:0] s, input int hold);
      an  = ~(4'(1) << k);
      seg = s;
      repeat (hold) @(negedge clk);
   endtask

   task automatic scan_frame(input logic [3:0][6:0] s);
      for (int k = 0; k < 4; k++) show(k, s[k], 10);
   endtask

   typedef struct {
      logic [3:0][6:0] segs;
      logic [15:0]     exp_dig;
      logic [3:0]      exp_err;
   } vec_t;

   vec_t vecs[5];
   int   base;

   initial begin
      // segs packed as {digit3, digit2, digit1, digit0}
      vecs[0] = '{{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 16'h1234, 4'b0000};
      vecs[1] = '{{7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 16'h5678, 4'b0000};
      vecs[2] = '{{7'b0010000, 7'b1000000, 7'b1111001, 7'b0100100}, 16'h9012, 4'b0000};
      vecs[3] = '{{7'b0110000, 7'b1111111, 7'b0010010, 7'b0000010}, 16'h3F56, 4'b0100};
      vecs[4] = '{{7'b0000000, 7'b1000000, 7'b1111000, 7'b0001000}, 16'h807F, 4'b0001};

      // Reset state
      do_reset();
      check("rst_digits", 32'(digits), 0);
      check("rst_ferr", 32'(frame_err), 0);
      check("rst_fv", 32'(frame_valid), 0);
      check("rst_stale", 32'(stale), 0);
      check("rst_conflict", 32'(conflict), 0);

      // Table of full frames, each from reset
      for (int i = 0; i < 5; i++) begin
         do_reset();
         base = fv_total;
         scan_frame(vecs[i].segs);
         check($sformatf("v%0d_pulses", i), 32'(fv_total - base), 1);
         check($sformatf("v%0d_digits", i), 32'(fv_dig), 32'(vecs[i].exp_dig));
         check($sformatf("v%0d_err", i), 32'(fv_err), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_latency", i), 32'(fv_cyc), 32'(37 + LAT_ADJ));
      end

      // Short dwell: never captures, times out
      do_reset();
      base = fv_total;
      for (int i = 0; i < 19; i++) show(i % 4, 7'b0011001, 3);
      check("short_stale_pre", 32'(stale), 0);
      show(3, 7'b0011001, 3);
      check("short_stale", 32'(stale), 1);
      check("short_pulses", 32'(fv_total - base), 0);

      // Conflict and blank: neither touches the seen mask
      do_reset();
      base = fv_total;
      show(0, 7'b1111001, 10);
      show(1, 7'b0100100, 10);
      check("conf_pre", 32'(conflict), 0);
      an = 4'b0011; seg = 7'b0110000;
      repeat (10) @(negedge clk);
      check("conf_set", 32'(conflict), 1);
      an = 4'b1111; seg = 7'b0000000;
      repeat (10) @(negedge clk);
      check("conf_sticky", 32'(conflict), 1);
      check("conf_no_frame", 32'(fv_total - base), 0);
      show(2, 7'b0110000, 10);
      show(3, 7'b0011001, 10);
      check("conf_pulses", 32'(fv_total - base), 1);
      check("conf_digits", 32'(fv_dig), 32'h4321);
      check("conf_latency", 32'(fv_cyc), 32'(57 + LAT_ADJ));
      do_reset();
      check("conf_cleared", 32'(conflict), 0);

      // Reset mid-frame discards partial captures
      show(0, 7'b0010000, 10);
      show(1, 7'b0010000, 10);
      do_reset();
      base = fv_total;
      show(2, 7'b0000010, 10);
      show(3, 7'b0010010, 10);
      check("rstmid_no_early", 32'(fv_total - base), 0);
      show(0, 7'b0000000, 10);
      show(1, 7'b1111000, 10);
      check("rstmid_pulses", 32'(fv_total - base), 1);
      check("rstmid_digits", 32'(fv_dig), 32'h5678);

      // Stale tie: completion lands on the edge the counter reaches STALE
      do_reset();
      base = fv_total;
      an = 4'b1111; seg = 7'b1111111;
      repeat (23 - LAT_ADJ) @(negedge clk);
      scan_frame(vecs[0].segs);
      check("tie_pulses", 32'(fv_total - base), 1);
      check("tie_cyc", 32'(fv_cyc), 60);
      check("tie_stale", 32'(fv_stale), 0);
      check("tie_digits", 32'(fv_dig), 32'h1234);
      while (cyc < 119) @(negedge clk);
      check("tie_restart_pre", 32'(stale), 0);
      @(negedge clk);
      check("tie_restart", 32'(stale), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
